// File: rtl/melody_pkg.sv
// ----------------------------------------------------------------------------
// melody_pkg
// Shared definitions for the melody sequencer:
//   - state_t           : sequencer state encoding
//   - HALF_PERIOD_TBL   : tone index 1..12 -> half-period in clk_en ticks
//                         (32.768 kHz / (2 * f), C4 = 63 ... B4 = 33)
//   - melody ROM byte field positions and the end-marker value
//   - tone_half_period(): table lookup, returns 0 for rest indices
// ----------------------------------------------------------------------------
package melody_pkg;

  localparam int HP_W      = 7;
  localparam int NUM_TONES = 12;

  // Melody ROM byte layout
  localparam int TONE_LSB = 0;
  localparam int TONE_MSB = 3;
  localparam int LEN_LSB  = 4;
  localparam int LEN_MSB  = 5;
  localparam int OCT_BIT  = 6;
  localparam int END_BIT  = 7;
  localparam logic END_MARKER = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_PLAY,
    ST_DONE
  } state_t;

  // Entry k holds the half-period of tone index k+1 (C4 .. B4).
  localparam logic [HP_W-1:0] HALF_PERIOD_TBL [NUM_TONES] = '{
    7'd63, 7'd59, 7'd56, 7'd53, 7'd50, 7'd47,
    7'd44, 7'd42, 7'd39, 7'd37, 7'd35, 7'd33
  };

  // Indices 0 and 13..15 are rests and map to a zero half-period.
  function automatic logic [HP_W-1:0] tone_half_period(input logic [3:0] tone);
    logic [HP_W-1:0] hp;
    hp = '0;
    if (tone >= 4'd1 && tone <= 4'd12) begin
      hp = HALF_PERIOD_TBL[tone - 4'd1];
    end
    return hp;
  endfunction

endpackage

// File: rtl/melody_seq_tone.sv
// ----------------------------------------------------------------------------
// melody_tone
// Square-wave generator for one note. While enabled, counts clk_en ticks and
// toggles the output every half_period ticks. A zero half_period is a rest.
// Dropping enable clears the counter and forces the output low at once.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   clk_en        : 32.768 kHz advance strobe
//   enable        : high while the sequencer is playing a note
//   half_period   : toggle interval in clk_en ticks (0 = rest)
//   tone_out      : buzzer drive
// ----------------------------------------------------------------------------
module melody_tone
  import melody_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk_en,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period,
  output logic            tone_out
);

  logic [HP_W-1:0] cnt;
  logic            tone_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      tone_q <= 1'b0;
    end else if (clk_en) begin
      if (!enable || half_period == '0) begin
        cnt    <= '0;
        tone_q <= 1'b0;
      end else if (cnt == half_period - HP_W'(1)) begin
        cnt    <= '0;
        tone_q <= ~tone_q;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
    end
  end

  // Gating with enable drops the output in the same cycle the note ends,
  // rather than one clk_en later when tone_q is cleared.
  assign tone_out = tone_q & enable;

endmodule

// File: rtl/melody_seq.sv
// ----------------------------------------------------------------------------
// melody_seq
// Plays tone/rest sequences from a byte-wide melody ROM as a square wave.
// Each ROM byte: [3:0] tone index, [5:4] length code L (2^L duration units),
// [6] octave, [7] end marker. Duration units are rising edges of
// divider_tick, sampled on clk_en cycles.
// Optional build macro: MELODY_OCTAVE_EN -- when defined, bit [6] halves the
// half-period (minimum 1); when undefined bit [6] is ignored.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   clk_en           : 32.768 kHz enable, all state advances only when high
//   divider_tick     : timebase tap, one duration unit per rising edge
//   melody_start     : command pulse, play from melody_addr
//   melody_stop      : command pulse, abort (wins over melody_start)
//   melody_loop      : level, restart at the start address on an end byte
//   melody_addr      : start address, sampled with melody_start
//   rom_addr         : melody ROM read address
//   rom_data         : ROM byte, valid one clk_en cycle after rom_addr changes
//   tone_out         : buzzer drive
//   busy             : high outside IDLE
//   melody_done      : high for the single DONE cycle on normal completion
// ----------------------------------------------------------------------------
module melody_seq
  import melody_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  input  logic              divider_tick,
  input  logic              melody_start,
  input  logic              melody_stop,
  input  logic              melody_loop,
  input  logic [ADDR_W-1:0] melody_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              tone_out,
  output logic              busy,
  output logic              melody_done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] start_addr;
  logic [3:0]        tone_idx;
  logic [1:0]        len_code;
  logic [2:0]        dur_cnt;
  logic [3:0]        units;
  logic              tick_q;
  logic              tick_edge;
  logic              note_end;
  logic              rom_is_end;
  logic              play_en;
  logic [HP_W-1:0]   half_period;

`ifdef MELODY_OCTAVE_EN
  logic              oct_q;
`else
  logic              unused_oct;
  assign unused_oct = rom_data[OCT_BIT];
`endif

  assign rom_addr   = ptr;
  assign rom_is_end = (rom_data[END_BIT] == END_MARKER);
  assign units      = 4'd1 << len_code;
  // tick_q holds divider_tick from the previous clk_en cycle.
  assign tick_edge  = divider_tick & ~tick_q;
  assign note_end   = tick_edge && ({1'b0, dur_cnt} == units - 4'd1);

  always_comb begin
    half_period = tone_half_period(tone_idx);
`ifdef MELODY_OCTAVE_EN
    if (oct_q && half_period > HP_W'(1)) begin
      half_period = half_period >> 1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != ST_IDLE);
    melody_done = (state == ST_DONE);
    play_en     = (state == ST_PLAY);
    if (clk_en) begin
      if (melody_stop) begin
        state_nxt = ST_IDLE;
      end else if (melody_start) begin
        state_nxt = ST_FETCH;
      end else begin
        case (state)
          ST_FETCH:  state_nxt = ST_WAIT;
          ST_WAIT:   state_nxt = ST_DECODE;
          ST_DECODE: begin
            if (rom_is_end) begin
              state_nxt = melody_loop ? ST_FETCH : ST_DONE;
            end else begin
              state_nxt = ST_PLAY;
            end
          end
          ST_PLAY:   if (note_end) state_nxt = ST_FETCH;
          ST_DONE:   state_nxt = ST_IDLE;
          default:   state_nxt = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      start_addr <= '0;
      tone_idx   <= '0;
      len_code   <= '0;
      dur_cnt    <= '0;
      tick_q     <= 1'b0;
`ifdef MELODY_OCTAVE_EN
      oct_q      <= 1'b0;
`endif
    end else if (clk_en) begin
      tick_q <= divider_tick;
      if (melody_stop) begin
        dur_cnt <= '0;
      end else if (melody_start) begin
        ptr        <= melody_addr;
        start_addr <= melody_addr;
        dur_cnt    <= '0;
      end else begin
        case (state)
          ST_DECODE: begin
            tone_idx <= rom_data[TONE_MSB:TONE_LSB];
            len_code <= rom_data[LEN_MSB:LEN_LSB];
`ifdef MELODY_OCTAVE_EN
            oct_q    <= rom_data[OCT_BIT];
`endif
            dur_cnt  <= '0;
            // Pointer wraps naturally at 2^ADDR_W; an end byte either
            // reloads the start address (loop) or leaves it in place.
            if (!rom_is_end) begin
              ptr <= ptr + ADDR_W'(1);
            end else if (melody_loop) begin
              ptr <= start_addr;
            end
          end
          ST_PLAY: begin
            if (tick_edge) begin
              dur_cnt <= note_end ? 3'd0 : dur_cnt + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  melody_tone u_tone (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_en      (clk_en),
    .enable      (play_en),
    .half_period (half_period),
    .tone_out    (tone_out)
  );

endmodule

// File: tb/tb_melody_seq.sv
`timescale 1ns/1ps
module tb_melody_seq;

  localparam int ADDR_W   = 8;
  localparam int TICK_BIT = 6;   // one duration unit = 128 clk_en cycles
`ifdef MELODY_OCTAVE_EN
  localparam int OCT_HP = 31;
`else
  localparam int OCT_HP = 63;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clk_en = 1'b0;
  logic              divider_tick = 1'b0;
  logic              melody_start = 1'b0;
  logic              melody_stop = 1'b0;
  logic              melody_loop = 1'b0;
  logic [ADDR_W-1:0] melody_addr = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h80;
  logic              tone_out;
  logic              busy;
  logic              melody_done;

  logic [7:0]  rom [256];
  int unsigned en_cnt = 0;
  int          done_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb [$];

  melody_seq #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk_en       (clk_en),
    .divider_tick (divider_tick),
    .melody_start (melody_start),
    .melody_stop  (melody_stop),
    .melody_loop  (melody_loop),
    .melody_addr  (melody_addr),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .tone_out     (tone_out),
    .busy         (busy),
    .melody_done  (melody_done)
  );

  always #5 clk = ~clk;

  // clk_en high on every other posedge; divider tap follows the clk_en count.
  initial forever begin
    @(negedge clk);
    clk_en = ~clk_en;
    divider_tick = en_cnt[TICK_BIT];
  end

  // ROM with one clk_en cycle latency, and a count of done cycles.
  always @(posedge clk) begin
    if (clk_en) begin
      en_cnt   <= en_cnt + 1;
      rom_data <= rom[rom_addr];
      if (melody_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic step();
    do @(posedge clk); while (clk_en !== 1'b1);
    #1;
  endtask

  function automatic logic [31:0] pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic align_tick();
    logic last;
    last = divider_tick;
    for (int i = 0; i < 400; i++) begin
      step();
      if (divider_tick && !last) break;
      last = divider_tick;
    end
  endtask

  task automatic cmd_start(input logic [7:0] a);
    melody_addr  = a;
    melody_start = 1'b1;
    step();
    melody_start = 1'b0;
  endtask

  task automatic cmd_stop();
    melody_stop = 1'b1;
    step();
    melody_stop = 1'b0;
  endtask

  // Observes one note from PLAY entry: counts tick rising edges seen on
  // clk_en cycles, records tone_out changes until the n-th edge, then follows
  // the three-cycle gap and returns at the cycle after the next DECODE.
  task automatic watch_play(input int n_edges, input int max_steps,
                            output int first_tgl, output int min_iv, output int max_iv,
                            output int hi_cnt, output int gap_hi, output int done_early,
                            output int exited);
    int   edges, exit_step, last_chg;
    logic last, cur, tone_prev;
    edges = 0; exit_step = -1; last_chg = -1;
    first_tgl = -1; min_iv = 1 << 30; max_iv = 0;
    hi_cnt = 0; gap_hi = 0; done_early = 0; exited = 0;
    last = divider_tick;
    tone_prev = tone_out;
    for (int i = 1; i <= max_steps; i++) begin
      step();
      cur = divider_tick;
      if (exit_step < 0 && cur && !last) begin
        edges++;
        if (edges == n_edges) exit_step = i;
      end
      last = cur;
      if (exit_step < 0) begin
        if (tone_out) hi_cnt++;
        if (tone_out !== tone_prev) begin
          if (first_tgl < 0) first_tgl = i;
          else begin
            if (i - last_chg < min_iv) min_iv = i - last_chg;
            if (i - last_chg > max_iv) max_iv = i - last_chg;
          end
          last_chg = i;
        end
        tone_prev = tone_out;
        if (melody_done) done_early++;
      end else if (i < exit_step + 3) begin
        if (tone_out) gap_hi++;
        if (melody_done) done_early++;
      end else begin
        exited = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0);
    repeat (4) @(posedge clk);
    #1;
    begin
      logic [31:0] e;
      checks++; e = pop_exp();
      if (32'(rom_addr) !== e) begin failures++; $display("FAIL reset_rom_addr got=%0h exp=%0h", rom_addr, e); end
      checks++; e = pop_exp();
      if (32'(tone_out) !== e) begin failures++; $display("FAIL reset_tone got=%0b exp=%0b", tone_out, e); end
      checks++; e = pop_exp();
      if (32'(busy) !== e) begin failures++; $display("FAIL reset_busy got=%0b exp=%0b", busy, e); end
      checks++; e = pop_exp();
      if (32'(melody_done) !== e) begin failures++; $display("FAIL reset_done got=%0b exp=%0b", melody_done, e); end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) step();
      checks++; e = pop_exp();
      if (32'(busy) !== e) begin failures++; $display("FAIL idle_busy got=%0b exp=%0b", busy, e); end
    end
  endtask

  task automatic test_tone();
    int ft, mn, mx, hi, gh, de, ex, d0;
    logic [31:0] e;
    rom[8'h10] = 8'h01;
    rom[8'h11] = 8'h80;
    align_tick();
    d0 = done_cnt;
    sb.push_back(32'h10); sb.push_back(1); sb.push_back(32'h11);
    sb.push_back(63); sb.push_back(1); sb.push_back(0); sb.push_back(1);
    sb.push_back(0); sb.push_back(d0 + 1);
    cmd_start(8'h10);
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL tone_fetch_addr got=%0h exp=%0h", rom_addr, e); end
    checks++; e = pop_exp();
    if (32'(busy) !== e) begin failures++; $display("FAIL tone_busy got=%0b exp=%0b", busy, e); end
    repeat (3) step();
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL tone_play_addr got=%0h exp=%0h", rom_addr, e); end
    watch_play(1, 400, ft, mn, mx, hi, gh, de, ex);
    checks++; e = pop_exp();
    if (ft !== int'(e)) begin failures++; $display("FAIL tone_first_toggle got=%0d exp=%0d", ft, e); end
    checks++; e = pop_exp();
    if (32'(melody_done) !== e) begin failures++; $display("FAIL tone_done got=%0b exp=%0b exited=%0d", melody_done, e, ex); end
    checks++; e = pop_exp();
    if (gh + de !== int'(e)) begin failures++; $display("FAIL tone_gap gap_hi=%0d done_early=%0d exp=%0d", gh, de, e); end
    step();
    checks++; e = pop_exp();
    if (32'(ex) !== e) begin failures++; $display("FAIL tone_exit got=%0d exp=%0d", ex, e); end
    checks++; e = pop_exp();
    if (32'(busy) !== e) begin failures++; $display("FAIL tone_busy_after got=%0b exp=%0b", busy, e); end
    checks++; e = pop_exp();
    if (done_cnt !== int'(e)) begin failures++; $display("FAIL tone_done_count got=%0d exp=%0d", done_cnt, e); end
  endtask

  task automatic test_rest();
    int ft, mn, mx, hi, gh, de, ex;
    logic [31:0] e;
    rom[8'h20] = 8'h30;
    rom[8'h21] = 8'h80;
    sb.push_back(32'h21); sb.push_back(0); sb.push_back(1); sb.push_back(0);
    cmd_start(8'h20);
    repeat (3) step();
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL rest_play_addr got=%0h exp=%0h", rom_addr, e); end
    watch_play(8, 1200, ft, mn, mx, hi, gh, de, ex);
    checks++; e = pop_exp();
    if (hi + gh !== int'(e)) begin failures++; $display("FAIL rest_tone_high got=%0d exp=%0d", hi + gh, e); end
    checks++; e = pop_exp();
    if (32'(melody_done) !== e) begin failures++; $display("FAIL rest_done got=%0b exp=%0b exited=%0d", melody_done, e, ex); end
    checks++; e = pop_exp();
    if (de !== int'(e)) begin failures++; $display("FAIL rest_done_early got=%0d exp=%0d", de, e); end
    step();
  endtask

  task automatic test_wrap();
    int ft, mn, mx, hi, gh, de, ex;
    logic [31:0] e;
    rom[8'hFF] = 8'h0A;
    rom[8'h00] = 8'h80;
    align_tick();
    sb.push_back(32'hFF); sb.push_back(32'h00); sb.push_back(37);
    sb.push_back(37); sb.push_back(37); sb.push_back(1);
    cmd_start(8'hFF);
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL wrap_fetch_addr got=%0h exp=%0h", rom_addr, e); end
    repeat (3) step();
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL wrap_addr got=%0h exp=%0h", rom_addr, e); end
    watch_play(1, 400, ft, mn, mx, hi, gh, de, ex);
    checks++; e = pop_exp();
    if (ft !== int'(e)) begin failures++; $display("FAIL wrap_first_toggle got=%0d exp=%0d", ft, e); end
    checks++; e = pop_exp();
    if (mn !== int'(e)) begin failures++; $display("FAIL wrap_min_interval got=%0d exp=%0d", mn, e); end
    checks++; e = pop_exp();
    if (mx !== int'(e)) begin failures++; $display("FAIL wrap_max_interval got=%0d exp=%0d", mx, e); end
    checks++; e = pop_exp();
    if (32'(melody_done) !== e) begin failures++; $display("FAIL wrap_done got=%0b exp=%0b exited=%0d", melody_done, e, ex); end
    step();
  endtask

  task automatic test_octave();
    int ft, mn, mx, hi, gh, de, ex;
    logic [31:0] e;
    rom[8'h50] = 8'h41;
    rom[8'h51] = 8'h80;
    align_tick();
    sb.push_back(OCT_HP); sb.push_back(1);
    cmd_start(8'h50);
    repeat (3) step();
    watch_play(1, 400, ft, mn, mx, hi, gh, de, ex);
    checks++; e = pop_exp();
    if (ft !== int'(e)) begin failures++; $display("FAIL octave_half_period got=%0d exp=%0d", ft, e); end
    checks++; e = pop_exp();
    if (32'(melody_done) !== e) begin failures++; $display("FAIL octave_done got=%0b exp=%0b", melody_done, e); end
    step();
  endtask

  task automatic test_loop();
    int ft, mn, mx, hi, gh, de, ex, d0, k;
    logic [31:0] e;
    rom[8'h30] = 8'h05;
    rom[8'h31] = 8'h80;
    melody_loop = 1'b1;
    align_tick();
    d0 = done_cnt;
    sb.push_back(32'h30); sb.push_back(0); sb.push_back(1); sb.push_back(32'h31);
    sb.push_back(0); sb.push_back(0); sb.push_back(d0);
    cmd_start(8'h30);
    repeat (3) step();
    watch_play(1, 400, ft, mn, mx, hi, gh, de, ex);
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL loop_restart_addr got=%0h exp=%0h", rom_addr, e); end
    checks++; e = pop_exp();
    if (32'(melody_done) !== e) begin failures++; $display("FAIL loop_no_done got=%0b exp=%0b", melody_done, e); end
    checks++; e = pop_exp();
    if (32'(busy) !== e) begin failures++; $display("FAIL loop_busy got=%0b exp=%0b", busy, e); end
    repeat (3) step();
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL loop_second_play_addr got=%0h exp=%0h", rom_addr, e); end
    for (k = 0; k < 150 && tone_out !== 1'b1; k++) step();
    cmd_stop();
    melody_loop = 1'b0;
    checks++; e = pop_exp();
    if (32'(busy) !== e) begin failures++; $display("FAIL loop_stop_busy got=%0b exp=%0b", busy, e); end
    checks++; e = pop_exp();
    if (32'(tone_out) !== e) begin failures++; $display("FAIL loop_stop_tone got=%0b exp=%0b", tone_out, e); end
    repeat (3) step();
    checks++; e = pop_exp();
    if (done_cnt !== int'(e)) begin failures++; $display("FAIL loop_done_count got=%0d exp=%0d", done_cnt, e); end
  endtask

  task automatic test_start_stop();
    int d0, k;
    logic [31:0] e;
    align_tick();
    cmd_start(8'h10);
    repeat (3) step();
    for (k = 0; k < 100 && tone_out !== 1'b1; k++) step();
    d0 = done_cnt;
    sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(d0);
    melody_addr  = 8'h20;
    melody_start = 1'b1;
    melody_stop  = 1'b1;
    step();
    melody_start = 1'b0;
    melody_stop  = 1'b0;
    checks++; e = pop_exp();
    if (32'(busy) !== e) begin failures++; $display("FAIL both_cmd_busy got=%0b exp=%0b", busy, e); end
    checks++; e = pop_exp();
    if (32'(tone_out) !== e) begin failures++; $display("FAIL both_cmd_tone got=%0b exp=%0b", tone_out, e); end
    repeat (4) step();
    checks++; e = pop_exp();
    if (32'(busy) !== e) begin failures++; $display("FAIL both_cmd_stays_idle got=%0b exp=%0b", busy, e); end
    checks++; e = pop_exp();
    if (done_cnt !== int'(e)) begin failures++; $display("FAIL both_cmd_done_count got=%0d exp=%0d", done_cnt, e); end
  endtask

  task automatic test_restart();
    int k;
    logic [31:0] e;
    rom[8'h60] = 8'h31;
    rom[8'h40] = 8'h31;
    rom[8'h41] = 8'h80;
    cmd_start(8'h60);
    repeat (3) step();
    for (k = 0; k < 100 && tone_out !== 1'b1; k++) step();
    repeat (20) step();
    sb.push_back(32'h40); sb.push_back(1); sb.push_back(0); sb.push_back(32'h41); sb.push_back(63);
    cmd_start(8'h40);
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL restart_addr got=%0h exp=%0h", rom_addr, e); end
    checks++; e = pop_exp();
    if (32'(busy) !== e) begin failures++; $display("FAIL restart_busy got=%0b exp=%0b", busy, e); end
    checks++; e = pop_exp();
    if (32'(tone_out) !== e) begin failures++; $display("FAIL restart_tone got=%0b exp=%0b", tone_out, e); end
    repeat (3) step();
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL restart_play_addr got=%0h exp=%0h", rom_addr, e); end
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (tone_out === 1'b1) begin k = i; break; end
    end
    checks++; e = pop_exp();
    if (k !== int'(e)) begin failures++; $display("FAIL restart_first_toggle got=%0d exp=%0d", k, e); end
    cmd_stop();
  endtask

  task automatic test_async_reset();
    int k;
    logic [31:0] e;
    align_tick();
    cmd_start(8'h10);
    repeat (3) step();
    for (k = 0; k < 100 && tone_out !== 1'b1; k++) step();
    sb.push_back(1); sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0); sb.push_back(0);
    checks++; e = pop_exp();
    if (32'(tone_out) !== e) begin failures++; $display("FAIL async_pre_tone got=%0b exp=%0b", tone_out, e); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; e = pop_exp();
    if (32'(tone_out) !== e) begin failures++; $display("FAIL async_tone got=%0b exp=%0b", tone_out, e); end
    checks++; e = pop_exp();
    if (32'(busy) !== e) begin failures++; $display("FAIL async_busy got=%0b exp=%0b", busy, e); end
    checks++; e = pop_exp();
    if (32'(rom_addr) !== e) begin failures++; $display("FAIL async_rom_addr got=%0h exp=%0h", rom_addr, e); end
    checks++; e = pop_exp();
    if (32'(melody_done) !== e) begin failures++; $display("FAIL async_done got=%0b exp=%0b", melody_done, e); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) step();
    checks++; e = pop_exp();
    if (32'(busy) !== e) begin failures++; $display("FAIL async_post_busy got=%0b exp=%0b", busy, e); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h80;
    test_reset();
    test_tone();
    test_rest();
    test_wrap();
    test_octave();
    test_loop();
    test_start_stop();
    test_restart();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/melody_seq.md
# melody_seq

Melody sequencer that plays tone/rest sequences from a byte-wide melody ROM as a square wave on the buzzer output. It sits directly downstream of the CPU timebase divider: it shares the 32.768 kHz `clk_en` strobe and uses one divider tap as its note-duration tick. The CPU starts and stops it through command pulses.

## Interface
Parameters:
- `ADDR_W`, 8: melody ROM address width.

Ports:
- `clk` in 1: system clock; sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clk_en` in 1: 32.768 kHz enable; all state advances only when high.
- `divider_tick` in 1: timebase tap (divider bit 11); each rising edge is one duration unit.
- `melody_start` in 1: command pulse; begin playing at `melody_addr`.
- `melody_stop` in 1: command pulse; abort playback.
- `melody_loop` in 1: level; on an end byte, restart at the start address instead of finishing.
- `melody_addr` in ADDR_W: start address, sampled with `melody_start`.
- `rom_addr` out ADDR_W: melody ROM read address.
- `rom_data` in 8: ROM byte, valid one clk_en cycle after `rom_addr` changes.
- `tone_out` out 1: square-wave buzzer drive.
- `busy` out 1: high in any state except IDLE.
- `melody_done` out 1: one-clk_en-cycle pulse on normal completion.

## Operation
- ROM byte fields: [3:0] tone index, where 0 and 13–15 are rests and 1–12 select half-period constants; [5:4] length code L, giving 2^L duration units; [6] octave; [7] end marker, where all other fields are ignored.
- States: IDLE → FETCH → WAIT → DECODE → PLAY → FETCH … ; an end byte goes to DONE, or to FETCH at the start address if `melody_loop` is set. DONE → IDLE.
- FETCH drives `rom_addr` = current pointer. WAIT waits for ROM latency. DECODE latches the byte and increments the pointer modulo 2^ADDR_W, so 0xFF wraps to 0x00.
- In PLAY, the tone counter counts clk_en ticks and toggles `tone_out` when it reaches half_period−1, then clears. A rest holds `tone_out` at 0.
- The duration counter counts rising edges of `divider_tick`, edge-detected on clk_en cycles. PLAY exits on the 2^L-th edge. The first unit may be partial, which is accepted.
- `tone_out` is forced to 0 on every exit from PLAY.
- `melody_stop` goes to IDLE next clk_en cycle from any state, with `tone_out`=0 and no `melody_done`.
- `melody_start` while busy restarts at the new address and clears both counters.
- `melody_start` and `melody_stop` in the same cycle: stop wins.
- Commands with `clk_en` low are ignored; the CPU holds them through a clk_en cycle.

## Timing
- Reset values: state IDLE, `rom_addr`=0, `tone_out`=0, `busy`=0, `melody_done`=0, counters 0, tick edge register 0.
- Start sampled at clk_en cycle N:
  - N+1: FETCH, `rom_addr`=start address, `busy`=1.
  - N+2: WAIT.
  - N+3: DECODE.
  - N+4: PLAY.
  - First toggle of `tone_out` comes half_period clk_en cycles after PLAY entry.
- Note-to-note gap: 3 clk_en cycles (FETCH/WAIT/DECODE) with `tone_out`=0.
- End byte: DECODE → DONE; `melody_done` is high for the single DONE cycle, then IDLE with `busy`=0.
- Async reset mid-note: all outputs take reset values immediately.

## Configuration
- `MELODY_OCTAVE_EN` defined: bit [6]=1 halves the half-period (right shift by 1; minimum 1).
- Not defined: bit [6] is ignored and the octave logic is absent.

## Structure
- Package `melody_pkg`:
  - state enum.
  - 12-entry half-period table; index 1 = 63 (C4), index 10 = 37 (A4).
  - field bit positions and the end-marker constant.
- Sub-module `melody_tone`: tone counter and `tone_out` toggle. Inputs are clk_en, enable, and half_period. Clearing enable resets the counter and drives the output to 0.

## Test plan
- Start at 0x10, ROM[0x10]=0x01 (tone 1, L=0), ROM[0x11]=0x80: `tone_out` toggles every 63 clk_en cycles for one tick unit, then `melody_done` pulses once and `busy` falls.
- ROM[0x20]=0x30 (rest, L=3), then end: `tone_out` stays 0 for 8 tick edges, then done.
- Start at 0xFF, ROM[0xFF]=0x0A, ROM[0x00]=0x80: `rom_addr` wraps to 0x00 and playback completes.
- `melody_loop`=1 with a 2-byte melody: after the end byte `rom_addr` returns to the start, with no `melody_done`. Stop then returns to IDLE with `tone_out`=0.
- `melody_start` and `melody_stop` in the same cycle while playing: IDLE, no restart. `reset_n` low mid-note: all outputs 0 immediately.
- With `MELODY_OCTAVE_EN`, byte 0x41: half-period 31. Without it: 63.
